// File: rtl/mips_defs.sv
// Shared encodings for the Lite MIPS32 multi-cycle controller: opcode/funct
// constants, ALU operation codes, PC source selects, FSM states and the
// instruction classes produced by the decoder.
package mips_defs;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  // ALU operation codes, identical to the ALU's own encoding
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_SLT   = 3'b011;
  localparam logic [2:0] ALU_PASSB = 3'b100;
  localparam logic [2:0] ALU_ADDV  = 3'b101;

  // PC source selects
  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXE    = 4'd2,
    S_ALU_WB = 4'd3,
    S_MEM_RD = 4'd4,
    S_MEM_WB = 4'd5,
    S_MEM_WR = 4'd6,
    S_BRANCH = 4'd7,
    S_JUMP   = 4'd8
  } state_t;

  typedef enum logic [3:0] {
    C_ADDU, C_SUBU, C_SLT, C_ORI, C_LUI, C_ADDI, C_ADDIU,
    C_LW, C_SW, C_BEQ, C_J, C_NONE
  } iclass_t;

  // Instructions that take their B operand from the immediate field
  function automatic logic is_itype(input iclass_t c);
    return (c == C_ORI) || (c == C_LUI) || (c == C_ADDI) || (c == C_ADDIU) ||
           (c == C_LW) || (c == C_SW);
  endfunction

  // ALU operation used while an instruction executes
  function automatic logic [2:0] alu_op_for(input iclass_t c);
    case (c)
      C_SUBU:  return ALU_SUB;
      C_ORI:   return ALU_OR;
      C_SLT:   return ALU_SLT;
      C_LUI:   return ALU_PASSB;
      C_ADDI:  return ALU_ADDV;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_instr_class.sv
// Combinational opcode/funct classifier. Unsupported encodings map to
// C_NONE with valid low.
module mc_instr_class
  import mips_defs::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output logic       valid
);

  // Classify the instruction held in the IR
  always_comb begin
    iclass = C_NONE;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: iclass = C_ADDU;
          FN_SUBU: iclass = C_SUBU;
          FN_SLT:  iclass = C_SLT;
          default: iclass = C_NONE;
        endcase
      end
      OP_ORI:   iclass = C_ORI;
      OP_LUI:   iclass = C_LUI;
      OP_ADDI:  iclass = C_ADDI;
      OP_ADDIU: iclass = C_ADDIU;
      OP_LW:    iclass = C_LW;
      OP_SW:    iclass = C_SW;
      OP_BEQ:   iclass = C_BEQ;
      OP_J:     iclass = C_J;
      default:  iclass = C_NONE;
    endcase
    valid = (iclass != C_NONE);
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle main controller: steps each instruction through fetch, decode,
// execute, memory and write-back and decodes the datapath controls from the
// current state and the instruction class.
module mc_control
  import mips_defs::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       dm_ready,
  output logic       IR_write,
  output logic       PC_write,
  output logic [1:0] PC_src,
  output logic [2:0] ALU_Op,
  output logic       ALU_src_B,
  output logic       ext_op,
  output logic       Reg_write,
  output logic       Reg_dst,
  output logic       Mem_to_reg,
  output logic       Mem_read,
  output logic       Mem_write,
  output logic       illegal,
  output logic       ovf_trap,
  output logic [3:0] state
);

  state_t  state_reg, state_next;
  iclass_t cls;
  logic    cls_valid;
  logic    addi_ovf;

  mc_instr_class u_class (
    .opcode (opcode),
    .funct  (funct),
    .iclass (cls),
    .valid  (cls_valid)
  );

  assign state    = state_reg;
  assign addi_ovf = (cls == C_ADDI) && overflow;

  // State register; reset returns to FETCH and abandons the instruction
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_FETCH;
    else     state_reg <= state_next;
  end

  // Next-state selection
  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        if (!cls_valid)          state_next = S_FETCH;
        else if (cls == C_BEQ)   state_next = S_BRANCH;
        else if (cls == C_J)     state_next = S_JUMP;
        else                     state_next = S_EXE;
      end
      S_EXE: begin
        if (cls == C_LW)         state_next = S_MEM_RD;
        else if (cls == C_SW)    state_next = S_MEM_WR;
        else                     state_next = S_ALU_WB;
      end
      S_MEM_RD: state_next = dm_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR: state_next = dm_ready ? S_FETCH : S_MEM_WR;
      default:  state_next = S_FETCH;
    endcase
  end

  // Output decode; everything is held low while reset is asserted
  always_comb begin
    IR_write   = 1'b0;
    PC_write   = 1'b0;
    PC_src     = PC_PLUS4;
    ALU_Op     = ALU_ADD;
    ALU_src_B  = 1'b0;
    ext_op     = 1'b0;
    Reg_write  = 1'b0;
    Reg_dst    = 1'b0;
    Mem_to_reg = 1'b0;
    Mem_read   = 1'b0;
    Mem_write  = 1'b0;
    illegal    = 1'b0;
    ovf_trap   = 1'b0;
    if (!rst) begin
      case (state_reg)
        S_FETCH: begin
          IR_write = 1'b1;
          PC_write = 1'b1;
          PC_src   = PC_PLUS4;
        end
        S_DECODE: illegal = !cls_valid;
        S_EXE, S_ALU_WB: begin
          // ALU controls stay put through write-back so the result is stable
          ALU_Op    = alu_op_for(cls);
          ALU_src_B = is_itype(cls);
          ext_op    = is_itype(cls) && (cls != C_ORI);
          if (state_reg == S_ALU_WB) begin
            Reg_write = !addi_ovf;
            ovf_trap  = addi_ovf;
            Reg_dst   = !is_itype(cls);
          end
        end
        S_MEM_RD: begin
          Mem_read  = 1'b1;
          ALU_Op    = ALU_ADD;
          ALU_src_B = 1'b1;
          ext_op    = 1'b1;
        end
        S_MEM_WB: begin
          Reg_write  = 1'b1;
          Mem_to_reg = 1'b1;
        end
        S_MEM_WR: begin
          // Address operands held until the memory accepts the write
          Mem_write = 1'b1;
          ALU_Op    = ALU_ADD;
          ALU_src_B = 1'b1;
          ext_op    = 1'b1;
        end
        S_BRANCH: begin
          ALU_Op   = ALU_SUB;
          PC_src   = PC_BRANCH;
          PC_write = zero;
        end
        S_JUMP: begin
          PC_src   = PC_JUMP;
          PC_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
